// File: rtl/f1_reaction_timer.sv
// F1 lights reaction timer: watches a0[7:0] for the start sequence and times lights-out to button press.
// Optional build macro F1RT_PRESCALE_EN counts in PRESCALE-cycle ticks instead of raw clock cycles.
module f1_reaction_timer #(
    parameter int COUNT_WIDTH = 16,
    parameter int PRESCALE    = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [31:0]            a0,
    input  logic                   btn,
    output logic                   result_valid,
    input  logic                   result_ready,
    output logic [COUNT_WIDTH-1:0] result_time,
    output logic                   false_start,
    output logic                   timeout
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] COUNTDOWN = 3'd1;
    localparam logic [2:0] ARMED     = 3'd2;
    localparam logic [2:0] TIMING    = 3'd3;
    localparam logic [2:0] RESULT    = 3'd4;

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    logic [2:0]             state;
    logic [7:0]             lights;
    logic [COUNT_WIDTH-1:0] counter;
    logic [COUNT_WIDTH-1:0] elapsed;
    logic [COUNT_WIDTH-1:0] counterNext;
    logic                   unusedBits;

    assign lights = a0[7:0];

`ifdef F1RT_PRESCALE_EN
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = '0;

    logic [PRE_W-1:0] prescaler;
    logic             tickNow;

    // The counter holds completed ticks up to the previous cycle; elapsed folds in a tick
    // completing this cycle so a press reports floor(cycles / PRESCALE) exactly.
    assign tickNow     = (prescaler == PRE_LAST);
    assign elapsed     = counter + COUNT_WIDTH'(tickNow);
    assign counterNext = elapsed;
    assign unusedBits  = ^a0[31:8];

    always_ff @(posedge clk) begin
        if (rst || state != TIMING) begin
            prescaler <= '0;
        end else if (tickNow) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end
`else
    localparam logic [COUNT_WIDTH-1:0] COUNT_LOAD = COUNT_WIDTH'(1);

    assign elapsed     = counter;
    assign counterNext = counter + COUNT_WIDTH'(1);
    assign unusedBits  = ^{a0[31:8], (PRESCALE % 2) == 1};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            result_valid <= 1'b0;
            result_time  <= '0;
            false_start  <= 1'b0;
            timeout      <= 1'b0;
            counter      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (lights != 8'h00) state <= COUNTDOWN;
                end
                COUNTDOWN: begin
                    if (btn) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_time  <= '0;
                        false_start  <= 1'b1;
                        timeout      <= 1'b0;
                    end else if (lights == 8'hFF) begin
                        state <= ARMED;
                    end else if (lights == 8'h00) begin
                        state <= IDLE;
                    end
                end
                ARMED: begin
                    // A press wins even when lights go out in the same cycle.
                    if (btn) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_time  <= '0;
                        false_start  <= 1'b1;
                        timeout      <= 1'b0;
                    end else if (lights == 8'h00) begin
                        state   <= TIMING;
                        counter <= COUNT_LOAD;
                    end
                end
                TIMING: begin
                    if (btn) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_time  <= elapsed;
                        false_start  <= 1'b0;
                        timeout      <= 1'b0;
                    end else if (elapsed == COUNT_MAX) begin
                        state        <= RESULT;
                        result_valid <= 1'b1;
                        result_time  <= COUNT_MAX;
                        false_start  <= 1'b0;
                        timeout      <= 1'b1;
                    end else begin
                        counter <= counterNext;
                    end
                end
                RESULT: begin
                    if (result_ready) begin
                        state        <= IDLE;
                        result_valid <= 1'b0;
                    end
                end
                default: begin
                    state        <= IDLE;
                    result_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
